butterfly_sequencer: RTL and testbench

//  Stage/butterfly scheduler driving the butterflyCore input side.
//  - Runs every radix-2 stage of an in-place FFT: butterfly index, twiddle index, iact, ictrl, ibfp.
//  - Consumes the core's write-back side (oact/octrl/bw_ramwrite) to detect stage completion.
//  - Tracks the block-floating-point width, so each stage is rescaled from the previous stage's result.

---
 rtl/butterfly_sequencer_if.sv | 29 ++
 rtl/butterfly_sequencer.sv | 145 ++++++++++++++
 tb/tb_butterfly_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/butterfly_sequencer_if.sv
// Core-side bus between butterfly_sequencer and butterflyCore.
//   master (sequencer): drives act/ctrl/mem_addr/tw_addr/ibfp/clr_bfp,
//                       receives write-back wb_act/wb_ctrl/bw_ramwrite.
//   slave  (core):      the mirror image.
// ctrl/wb_ctrl encoding: [0] = first butterfly of a stage, [1] = last.
interface butterfly_sequencer_if #(
  parameter int FFT_N     = 10,
  parameter int FFT_BFPDW = 5
);
  logic                 act;
  logic [1:0]           ctrl;
  logic [FFT_N-2:0]     mem_addr;
  logic [FFT_N-2:0]     tw_addr;
  logic [FFT_BFPDW-1:0] ibfp;
  logic                 clr_bfp;
  logic                 wb_act;
  logic [1:0]           wb_ctrl;
  logic [FFT_BFPDW-1:0] bw_ramwrite;

  modport master (
    output act, ctrl, mem_addr, tw_addr, ibfp, clr_bfp,
    input  wb_act, wb_ctrl, bw_ramwrite
  );

  modport slave (
    input  act, ctrl, mem_addr, tw_addr, ibfp, clr_bfp,
    output wb_act, wb_ctrl, bw_ramwrite
  );
endinterface

// File: rtl/butterfly_sequencer.sv
// Stage/butterfly scheduler for an in-place radix-2 FFT on butterflyCore.
// Issues every butterfly of every stage, waits for the stage's last
// write-back before starting the next (RAW hazard), and carries the
// block-floating-point width forward as the next stage's input shift.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start          begin an FFT (honoured only when idle)
//   hold           stall issue (RAM arbitration)
//   ibfp_init      stage-0 shift, sampled on accepted start
//   busy, done     run in progress / one-cycle completion pulse
//   stage          current stage index
//   core           core-side bus (issue + write-back)
//   scale_exp      saturating sum of all applied shifts
//   err            sticky protocol error
module butterfly_sequencer #(
  parameter int FFT_N     = 10,
  parameter int FFT_BFPDW = 5,
  parameter int SCALE_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   hold,
  input  logic [FFT_BFPDW-1:0]   ibfp_init,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(FFT_N):0] stage,
  butterfly_sequencer_if.master  core,
  output logic [SCALE_W-1:0]     scale_exp,
  output logic                   err
);
  localparam int ST_W = $clog2(FFT_N) + 1;
  localparam int J_W  = FFT_N - 1;
  localparam logic [J_W-1:0]  J_LAST  = '1;               // 2^(FFT_N-1)-1
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(FFT_N - 1);
  localparam logic [ST_W-1:0] TW_TOP  = ST_W'(J_W);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, UPDATE, FIN} state_t;

  state_t               state_q, state_d;
  logic [ST_W-1:0]      stage_q;
  logic [J_W-1:0]       j_q;
  logic [FFT_BFPDW-1:0] ibfp_q;
  logic [FFT_BFPDW-1:0] stage_bw_q;
  logic [SCALE_W-1:0]   scale_q;
  logic [J_W-1:0]       wb_cnt_q;
  logic                 last_ok_q;  // correct last write-back already seen
  logic                 err_q;

  logic                 issue;
  logic                 in_flight;
  logic                 wb_last;
  logic                 err_set;
  logic [SCALE_W:0]     scale_sum;
  logic [FFT_N-1:0]     one_hot;
  logic [J_W-1:0]       tw_mask;

  assign in_flight = (state_q == ISSUE) || (state_q == DRAIN);
  assign wb_last   = core.wb_act && core.wb_ctrl[1];
  assign scale_sum = {1'b0, scale_q} + (SCALE_W+1)'(stage_bw_q);

  // Twiddle index: low 'stage' bits of j, left-aligned in the ROM index.
  assign one_hot = FFT_N'(1) << stage_q;
  assign tw_mask = J_W'(one_hot - FFT_N'(1));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = ISSUE;
      ISSUE:  if (!hold) begin
                issue = 1'b1;
                if (j_q == J_LAST) state_d = DRAIN;
              end
      // A zero-latency core may deliver the last write-back while still
      // issuing; last_ok_q remembers it so DRAIN does not wait forever.
      DRAIN:  if (wb_last || last_ok_q) state_d = UPDATE;
      UPDATE: state_d = (stage_q == ST_LAST) ? FIN : ISSUE;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign err_set = (core.wb_act && !in_flight)
                || (in_flight && wb_last && (wb_cnt_q != J_LAST))
                || ((state_q == UPDATE) && scale_sum[SCALE_W]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      j_q        <= '0;
      ibfp_q     <= '0;
      stage_bw_q <= '0;
      scale_q    <= '0;
      wb_cnt_q   <= '0;
      last_ok_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) err_q <= 1'b1;
      if (issue) j_q <= j_q + 1'b1;
      if (in_flight && core.wb_act) begin
        wb_cnt_q <= wb_cnt_q + 1'b1;
        if (core.bw_ramwrite > stage_bw_q) stage_bw_q <= core.bw_ramwrite;
        if (core.wb_ctrl[1] && (wb_cnt_q == J_LAST)) last_ok_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (start) begin
          stage_q    <= '0;
          j_q        <= '0;
          ibfp_q     <= ibfp_init;
          scale_q    <= SCALE_W'(ibfp_init);
          stage_bw_q <= '0;
          wb_cnt_q   <= '0;
          last_ok_q  <= 1'b0;
        end
        UPDATE: begin
          ibfp_q     <= stage_bw_q;
          scale_q    <= scale_sum[SCALE_W] ? '1 : scale_sum[SCALE_W-1:0];
          stage_bw_q <= '0;
          wb_cnt_q   <= '0;
          last_ok_q  <= 1'b0;
          j_q        <= '0;
          if (stage_q != ST_LAST) stage_q <= stage_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Issue side is combinational from state so a hold release has no bubble.
  assign core.act      = issue;
  assign core.ctrl     = issue ? {j_q == J_LAST, j_q == '0} : 2'b00;
  assign core.mem_addr = j_q;
  assign core.tw_addr  = (j_q & tw_mask) << (TW_TOP - stage_q);
  assign core.ibfp     = ibfp_q;
  assign core.clr_bfp  = (state_q == UPDATE);

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign stage     = stage_q;
  assign scale_exp = scale_q;
  assign err       = err_q;
endmodule

// File: tb/tb_butterfly_sequencer.sv
module tb_butterfly_sequencer;
  localparam int N  = 3;
  localparam int BW = 5;
  localparam int SW = 8;

  localparam int TW    [3][4] = '{'{0,0,0,0}, '{0,2,0,2}, '{0,1,2,3}};
  localparam int CT    [4]    = '{1, 0, 0, 2};
  localparam int IDX_H [4]    = '{0, 4, 5, 6};
  localparam logic [BW-1:0] BW_TAB [4] = '{5'd1, 5'd4, 5'd2, 5'd0};

  logic clk = 0, rst = 0, start = 0, hold = 0;
  logic [BW-1:0] ibfp_init = '0;
  logic busy, done, err;
  logic [2:0] stage;
  logic [SW-1:0] scale_exp;

  bit dly_mode = 0, tab_mode = 0, inj_act = 0;
  logic [1:0] inj_ctrl = 2'b00;
  int n_chk = 0, n_err = 0;

  butterfly_sequencer_if #(.FFT_N(N), .FFT_BFPDW(BW)) bif();

  butterfly_sequencer #(.FFT_N(N), .FFT_BFPDW(BW), .SCALE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .ibfp_init(ibfp_init),
    .busy(busy), .done(done), .stage(stage), .core(bif),
    .scale_exp(scale_exp), .err(err)
  );

  always #5 clk = ~clk;

  // Core model: fixed 4-cycle write-back latency.
  logic [3:0]      p_act;
  logic [3:0][1:0] p_ctrl, p_addr;
  int dly;
  logic late, mask_last;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_act <= '0; p_ctrl <= '0; p_addr <= '0;
    end else begin
      p_act  <= {p_act[2:0], bif.act};
      p_ctrl <= {p_ctrl[2:0], bif.ctrl};
      p_addr <= {p_addr[2:0], bif.mem_addr};
    end
  end

  assign mask_last = dly_mode && p_ctrl[3][1] && (stage == 3'd0);
  always @(posedge clk or negedge rst) begin
    if (!rst) dly <= 0;
    else if (p_act[3] && mask_last) dly <= 20;
    else if (dly != 0) dly <= dly - 1;
  end
  assign late = (dly == 1);

  assign bif.wb_act      = (p_act[3] && !mask_last) || late || inj_act;
  assign bif.wb_ctrl     = inj_act ? inj_ctrl : (late ? 2'b10 : p_ctrl[3]);
  assign bif.bw_ramwrite = (tab_mode && !inj_act && !late) ? BW_TAB[p_addr[3]] : 5'd3;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {busy, done, stage, bif.act, bif.ctrl, bif.mem_addr,
        bif.tw_addr, bif.ibfp, bif.clr_bfp, scale_exp, err}, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #2 rst = 0;
    #1 chk_zero(tag);
    @(negedge clk); rst = 1;
  endtask

  task automatic run_fft(input int init, input bit hmode, input bit dmode,
                         input bit tmode, input bit mid_start, input bit exp_err);
    int n = 0, sc = 0, prev_st = -1, last_cyc = 0, nclr = 0, ndone = 0, nviol = 0;
    int bw_s, st, e_idx;
    bit fin = 0;
    dly_mode = dmode; tab_mode = tmode;
    bw_s = tmode ? 4 : 3;
    @(negedge clk); start = 1; ibfp_init = init[BW-1:0];
    @(negedge clk); start = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      st = int'(stage);
      if (st != prev_st) sc = 0; else sc++;
      prev_st = st;
      hold  = (hmode && st == 1 && sc >= 1 && sc <= 3) || (dmode && st == 0 && sc >= 4);
      start = mid_start && cyc == 10;
      #1;
      if ((hold || bif.clr_bfp) && bif.act) nviol++;
      if (!busy) nviol++;
      if (bif.clr_bfp) nclr++;
      if (bif.act) begin
        if (n < 12) begin
          e_idx = (hmode && n / 4 == 1) ? IDX_H[n % 4] : n % 4;
          chk("stage", stage, n / 4);
          chk("mem_addr", bif.mem_addr, n % 4);
          chk("tw_addr", bif.tw_addr, TW[n / 4][n % 4]);
          chk("ctrl", bif.ctrl, CT[n % 4]);
          chk("ibfp", bif.ibfp, (n < 4) ? init : bw_s);
          chk("issue_slot", sc, e_idx);
          if (n % 4 == 0 && n > 0)
            chk("stage_gap", cyc - last_cyc, (dmode && n == 4) ? 26 : 6);
        end
        n++;
        last_cyc = cyc;
      end
      if (done) begin ndone++; fin = 1; end
    end
    hold = 0; start = 0;
    chk("done_seen", ndone, 1);
    chk("n_act", n, 12);
    chk("n_clr", nclr, 3);
    chk("violations", nviol, 0);
    @(negedge clk); #1;
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
    chk("scale_exp", scale_exp, init + 3 * bw_s);
    chk("ibfp_final", bif.ibfp, bw_s);
    chk("err", err, exp_err);
    dly_mode = 0; tab_mode = 0;
  endtask

  initial begin
    int found;
    #3 chk_zero("reset");
    @(negedge clk); rst = 1;

    run_fft(2, 0, 0, 0, 0, 0);   // basic run
    run_fft(2, 1, 0, 0, 0, 0);   // hold in stage-1 issue
    run_fft(2, 0, 0, 1, 1, 0);   // bw table, start while busy
    run_fft(2, 0, 1, 0, 0, 0);   // late last write-back, hold in drain

    // write-back while idle -> sticky err
    @(negedge clk); inj_act = 1; inj_ctrl = 2'b00;
    #1 chk("err_pre_idle", err, 0);
    @(negedge clk); inj_act = 0;
    #1 chk("err_idle_wb", err, 1);
    run_fft(1, 0, 0, 0, 0, 1);

    // early last write-back
    do_reset("rst_a");
    @(negedge clk); start = 1; ibfp_init = 5'd2;
    @(negedge clk); start = 0; inj_act = 1; inj_ctrl = 2'b10;
    #1 chk("err_pre_early", err, 0);
    @(negedge clk); inj_act = 0; inj_ctrl = 2'b00;
    #1 chk("err_early", err, 1);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk); #1;
      if (done) found = 1;
    end
    chk("early_done", found, 1);
    @(negedge clk); #1 chk("err_sticky", err, 1);

    // reset mid stage 1, then a clean run
    do_reset("rst_b");
    @(negedge clk); start = 1; ibfp_init = 5'd2;
    @(negedge clk); start = 0;
    for (int i = 0; i < 50 && stage != 3'd1; i++) @(negedge clk);
    chk("reach_stage1", stage, 1);
    do_reset("rst_mid");
    run_fft(5, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
